uart_tx_sfr_v1: RTL
===================

// Module: uart_tx_sfr_v1
// PURPOSE
//  Memory-mapped UART transmitter: a bus responder on the CPU SFR bus (decoded SFR write strobe, combinational OR-ed read).
//  CPU pushes bytes into a TX FIFO via SFR writes; the serial engine shifts them out as 8N1 frames on tx_out.
//  Sits beside the TMR/PWM/DCO peripherals; its sfr_rd_dout joins the SFR read OR-bus.
// PARAMETERS
//  DATA_WIDTH   32            SFR/bus data width
//  ADDR_WIDTH   32            bus address width
//  BASE_ADDR    32'hFFFFF864  address of UTXCON; UTXBRG=+4, UTXDAT=+8, UTXSTA=+12
//  FIFO_DEPTH   8             TX FIFO entries; power of 2, range 2..128
// PORTS
//  sys_clk        in   1           system clock, all logic on rising edge
//  sys_rst        in   1           synchronous reset, active-high
//  sys_clk_en     in   1           engine enable; 0 freezes baud counter and FSM; SFR access unaffected
//  sys_addr       in   ADDR_WIDTH  bus address
//  sys_wr_en      in   1           SFR-region write strobe, already decoded
//  sys_sw_value   in   DATA_WIDTH  write data
//  sfr_rd_dout    out  DATA_WIDTH  read data for the addressed SFR; all-zero when no SFR of this block is addressed
//  tx_out         out  1           serial line, idle high
//  tx_done_event  out  1           1-cycle pulse at end of each stop bit
//  tx_empty_event out  1           1-cycle pulse when the FIFO level goes 1->0 due to a pop
// BEHAVIOUR
//  Reset: all SFRs 0, FIFO empty, FSM IDLE, tx_out=1, both events 0. Reset mid-frame aborts the frame; tx_out=1 after the reset edge.
//  SFRs; unimplemented bits read 0 and ignore writes:
//   UTXCON [0] EN; [1] FLUSH: write 1 empties FIFO that edge, self-clears, reads 0.
//   UTXBRG [15:0] BRG; bit time = BRG+1 sys_clk cycles (BRG=0 gives 1 cycle/bit).
//   UTXDAT write [7:0] pushes one byte; reads 0.
//   UTXSTA RO: [0] BUSY (FSM not IDLE), [1] FULL, [2] EMPTY, [15:8] FIFO level.
//          [3] OVF: sticky; write 1 clears; set has priority over clear in the same cycle.
//  Reads: combinational, side-effect free, match on full address equality.
//  FIFO:
//   Push to a full FIFO is dropped and sets OVF, except a push and a pop in the same cycle, which both succeed.
//   FLUSH in the same cycle as a push: FIFO ends empty.
//  FSM: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE or START.
//   IDLE: when EN=1, FIFO non-empty and sys_clk_en=1, pop into shift reg -> START.
//    tx_out=0 from the edge after the write edge that filled the empty FIFO.
//   Each state holds tx_out for BRG+1 enabled cycles, counted by a 16-bit down-counter reloaded from BRG at every bit boundary.
//   BRG written mid-frame takes effect at the next bit boundary.
//   STOP end: pulse tx_done_event. If EN=1 and FIFO non-empty, pop -> START with no idle gap; else -> IDLE.
//   Frame = 10*(BRG+1) cycles.
//   EN cleared mid-frame: current frame completes, then IDLE; FIFO retained.
//   FLUSH mid-frame: FIFO emptied, frame in flight completes.
//   sys_clk_en=0: counter, FSM and tx_out hold; no pop occurs.
// TESTING
//  1 Reset, BRG=3, EN=1, write UTXDAT=0xA5.
//    -> tx_out low 1 cycle after write; line 0,1,0,1,0,0,1,0,1,1 with 4 cycles/bit (start, LSB-first data, stop).
//    -> tx_done_event exactly at cycle 40.
//  2 BRG=0, EN=0, push 3 bytes, then set EN.
//    -> 3 frames back-to-back, 30 cycles, no idle gap.
//    -> UTXSTA level 3->0; tx_empty_event on the 3rd pop; BUSY falls after the last stop bit.
//  3 EN=0, FIFO_DEPTH=8, push 9 bytes.
//    -> FULL=1, level=8, OVF=1, 9th byte never transmitted.
//    -> write UTXSTA[3]=1 clears OVF.
//  4 Mid-frame of 0x3C: clear EN and write FLUSH with 2 bytes queued.
//    -> 0x3C frame completes; then IDLE, EMPTY=1, tx_out=1.
//  5 Toggle sys_clk_en low for 5 cycles mid-bit.
//    -> that bit lasts BRG+1+5 cycles; the rest of the frame is unchanged.
//    -> sys_rst asserted mid-frame -> tx_out=1 and all SFRs 0 after the reset edge.
//  6 Read a non-matching address and each SFR.
//    -> sfr_rd_dout=0 for the non-matching address; UTXDAT reads 0; UTXCON[1] reads 0.

Source files
------------

// File: rtl/uart_tx_sfr_v1.sv
// uart_tx_sfr_v1: SFR-mapped 8N1 UART transmitter with a TX FIFO.
// The SFR bus interface is a decoded write strobe. Reads are combinational and feed the SFR OR-bus.
// Ports:
//   sys_clk/sys_rst/sys_clk_en  clock, synchronous active-high reset, engine enable
//   sys_addr/sys_wr_en/sys_sw_value/sfr_rd_dout  SFR access
//   tx_out  serial line. tx_done_event: pulse when a stop bit ends. tx_empty_event: pulse when a pop empties the FIFO.
module uart_tx_sfr_v1 #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'hFFFFF864,
  parameter int                    FIFO_DEPTH = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  sys_clk_en,
  input  logic [ADDR_WIDTH-1:0] sys_addr,
  input  logic                  sys_wr_en,
  input  logic [DATA_WIDTH-1:0] sys_sw_value,
  output logic [DATA_WIDTH-1:0] sfr_rd_dout,
  output logic                  tx_out,
  output logic                  tx_done_event,
  output logic                  tx_empty_event
);

  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [ADDR_WIDTH-1:0] A_CON = BASE_ADDR;
  localparam logic [ADDR_WIDTH-1:0] A_BRG = BASE_ADDR + ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] A_DAT = BASE_ADDR + ADDR_WIDTH'(8);
  localparam logic [ADDR_WIDTH-1:0] A_STA = BASE_ADDR + ADDR_WIDTH'(12);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Architectural registers
  logic        en;
  logic [15:0] brg;
  logic        ovf;

  // FIFO storage
  logic [7:0]  mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   fifo_cnt;
  logic          fifo_full, fifo_empty;
  logic [7:0]    level8;

  // Serial engine
  logic [1:0]  state;
  logic [15:0] bit_cnt;
  logic [7:0]  shift;
  logic [2:0]  bit_idx;
  logic        bit_end;

  // Bus decode
  logic wr_con, wr_brg, wr_dat, wr_sta;
  logic flush, push_ok, ovf_set, pop;

  always_comb begin
    wr_con     = sys_wr_en && (sys_addr == A_CON);
    wr_brg     = sys_wr_en && (sys_addr == A_BRG);
    wr_dat     = sys_wr_en && (sys_addr == A_DAT);
    wr_sta     = sys_wr_en && (sys_addr == A_STA);
    flush      = wr_con && sys_sw_value[1];
    fifo_empty = (fifo_cnt == '0);
    fifo_full  = (fifo_cnt == (PW+1)'(FIFO_DEPTH));
    level8     = 8'(fifo_cnt);
    bit_end    = (bit_cnt == 16'd0);
    // A pop starts a frame from IDLE, or chains a frame directly off the end of a stop bit.
    pop        = en && !fifo_empty && sys_clk_en &&
                 ((state == S_IDLE) || ((state == S_STOP) && bit_end));
    // A simultaneous pop frees a slot, so a push to a full FIFO still lands.
    push_ok    = wr_dat && !flush && (!fifo_full || pop);
    ovf_set    = wr_dat && !flush && fifo_full && !pop;
  end

  // SFRs, FIFO pointers and level
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      en             <= 1'b0;
      brg            <= 16'd0;
      ovf            <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_cnt       <= '0;
      tx_empty_event <= 1'b0;
    end else begin
      if (wr_con) en  <= sys_sw_value[0];
      if (wr_brg) brg <= sys_sw_value[15:0];
      if (ovf_set)                      ovf <= 1'b1;
      else if (wr_sta && sys_sw_value[3]) ovf <= 1'b0;
      // A flush that empties the FIFO does not count as a pop-driven empty.
      tx_empty_event <= pop && (fifo_cnt == (PW+1)'(1)) && !push_ok && !flush;
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fifo_cnt <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        case ({push_ok, pop})
          2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
          2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
          default: fifo_cnt <= fifo_cnt;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push_ok) mem[wr_ptr] <= sys_sw_value[7:0];
  end

  // Serial engine. tx_out is registered and changes only at bit boundaries.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= S_IDLE;
      bit_cnt       <= 16'd0;
      shift         <= 8'd0;
      bit_idx       <= 3'd0;
      tx_out        <= 1'b1;
      tx_done_event <= 1'b0;
    end else begin
      tx_done_event <= 1'b0;
      if (sys_clk_en) begin
        case (state)
          S_IDLE: begin
            if (pop) begin
              shift   <= mem[rd_ptr];
              bit_cnt <= brg;
              tx_out  <= 1'b0;
              state   <= S_START;
            end
          end
          S_START: begin
            if (bit_end) begin
              tx_out  <= shift[0];
              shift   <= shift >> 1;
              bit_idx <= 3'd0;
              bit_cnt <= brg;
              state   <= S_DATA;
            end else begin
              bit_cnt <= bit_cnt - 16'd1;
            end
          end
          S_DATA: begin
            if (bit_end) begin
              bit_cnt <= brg;
              if (bit_idx == 3'd7) begin
                tx_out <= 1'b1;
                state  <= S_STOP;
              end else begin
                tx_out  <= shift[0];
                shift   <= shift >> 1;
                bit_idx <= bit_idx + 3'd1;
              end
            end else begin
              bit_cnt <= bit_cnt - 16'd1;
            end
          end
          default: begin // S_STOP
            if (bit_end) begin
              tx_done_event <= 1'b1;
              if (pop) begin
                shift   <= mem[rd_ptr];
                bit_cnt <= brg;
                tx_out  <= 1'b0;
                state   <= S_START;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt - 16'd1;
            end
          end
        endcase
      end
    end
  end

  // Combinational, side-effect-free read mux
  always_comb begin
    sfr_rd_dout = '0;
    case (sys_addr)
      A_CON: sfr_rd_dout[0]    = en;
      A_BRG: sfr_rd_dout[15:0] = brg;
      A_STA: begin
        sfr_rd_dout[0]    = (state != S_IDLE);
        sfr_rd_dout[1]    = fifo_full;
        sfr_rd_dout[2]    = fifo_empty;
        sfr_rd_dout[3]    = ovf;
        sfr_rd_dout[15:8] = level8;
      end
      default: sfr_rd_dout = '0;
    endcase
  end

endmodule
